// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse decoder: frame FSM states, packet bit positions, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Bit positions inside packet byte 0
    localparam int BTN_LEFT_BIT   = 0;
    localparam int BTN_RIGHT_BIT  = 1;
    localparam int BTN_MIDDLE_BIT = 2;
    localparam int SYNC_BIT       = 3;
    localparam int X_SIGN_BIT     = 4;
    localparam int Y_SIGN_BIT     = 5;
    localparam int X_OVF_BIT      = 6;
    localparam int Y_OVF_BIT      = 7;

    localparam int DEF_X_MAX          = 639;
    localparam int DEF_Y_MAX          = 479;
    localparam int DEF_TIMEOUT_CYCLES = 100000;
    localparam int DEF_FILTER_LEN     = 8;

    // Saturate an 18-bit signed position into 0..max_v
    function automatic logic [15:0] clamp_pos(input logic signed [17:0] v,
                                              input logic [15:0]        max_v);
        logic signed [17:0] max_s;
        max_s = $signed({2'b00, max_v});
        if (v < 18'sd0)
            return 16'd0;
        else if (v > max_s)
            return max_v;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: 2-flop sync + stability filter on both lines, 11-bit frame FSM with idle timeout.
// Latency: byte_valid/byte_err are combinational in the cycle the stop bit is sampled (or timeout expires).
// Backpressure: none; the PS/2 device cannot be stalled, consumer must accept every pulse.
// Optional: PS2_PARITY_CHECK_EN enables odd-parity checking of each byte.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err
);

    localparam int CW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // index 0 = PS/2 clock line, index 1 = PS/2 data line
    logic [1:0]    w_lines;
    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_filt;
    logic [CW-1:0] r_cnt [2];
    logic          r_clk_filt_d;
    logic          w_fall;
    logic          w_dat;

    frame_state_t  r_state, w_nxt_state;
    logic [7:0]    r_shift, w_nxt_shift;
    logic [2:0]    r_bit_cnt, w_nxt_bit_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;
`ifdef PS2_PARITY_CHECK_EN
    logic          r_par_ok, w_nxt_par_ok;
`endif

    assign w_lines = {ps2_data_i, ps2_clk_i};
    assign w_fall  = r_clk_filt_d & ~r_filt[0];
    assign w_dat   = r_filt[1];

    // Synchronize both lines and accept a new level only after FILTER_LEN stable clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1         <= 2'b11;
            r_s2         <= 2'b11;
            r_filt       <= 2'b11;
            r_clk_filt_d <= 1'b1;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            r_s1         <= w_lines;
            r_s2         <= r_s1;
            r_clk_filt_d <= r_filt[0];
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Idle-clock counter: runs only mid-frame, cleared by every filtered falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (r_state == ST_IDLE || w_fall)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM state and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef PS2_PARITY_CHECK_EN
            r_par_ok  <= 1'b0;
`endif
        end else begin
            r_state   <= w_nxt_state;
            r_shift   <= w_nxt_shift;
            r_bit_cnt <= w_nxt_bit_cnt;
`ifdef PS2_PARITY_CHECK_EN
            r_par_ok  <= w_nxt_par_ok;
`endif
        end
    end

    // Frame FSM next state and byte outputs
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_shift   = r_shift;
        w_nxt_bit_cnt = r_bit_cnt;
`ifdef PS2_PARITY_CHECK_EN
        w_nxt_par_ok  = r_par_ok;
`endif
        byte_valid    = 1'b0;
        byte_err      = 1'b0;
        byte_data     = r_shift;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    // a high start bit is noise, stay idle
                    if (!w_dat) begin
                        w_nxt_state   = ST_DATA;
                        w_nxt_bit_cnt = '0;
                    end
                end
                ST_DATA: begin
                    w_nxt_shift = {w_dat, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7)
                        w_nxt_state = ST_PARITY;
                    else
                        w_nxt_bit_cnt = r_bit_cnt + 1'b1;
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    w_nxt_par_ok = ^{r_shift, w_dat};
`endif
                    w_nxt_state = ST_STOP;
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    if (!w_dat)
                        byte_err = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    else if (!r_par_ok)
                        byte_err = 1'b1;
`endif
                    else
                        byte_valid = 1'b1;
                end
            endcase
        end else if (w_timeout) begin
            w_nxt_state = ST_IDLE;
            byte_err    = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse decoder: assembles 3-byte packets and applies clamped deltas to cursor position/buttons.
// Latency: pkt_valid/outputs update one clock after the stop bit of byte 2 is sampled.
// Backpressure: none; packets are applied as they arrive. Optional: PS2_PARITY_CHECK_EN.
module ps2_mouse_decoder
    import ps2_pkg::*;
#(
    parameter int X_MAX          = DEF_X_MAX,
    parameter int Y_MAX          = DEF_Y_MAX,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [15:0] mouse_x,
    output logic [15:0] mouse_y,
    output logic [7:0]  mouse_click,
    output logic        pkt_valid,
    output logic        frame_err
);

    localparam logic [15:0] X_MAX_W = 16'(X_MAX);
    localparam logic [15:0] Y_MAX_W = 16'(Y_MAX);

    logic               w_byte_valid;
    logic [7:0]         w_byte_data;
    logic               w_byte_err;
    logic [1:0]         r_idx;
    logic [7:0]         r_b0;
    logic [7:0]         r_b1;
    logic signed [17:0] w_dx;
    logic signed [17:0] w_dy;
    logic signed [17:0] w_sum_x;
    logic signed [17:0] w_sum_y;
    logic               w_unused_sync;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .byte_err   (w_byte_err)
    );

    // sync bit only matters when byte 0 is first accepted
    assign w_unused_sync = r_b0[SYNC_BIT];

    // 9-bit deltas sign-extended to 18 bits; overflow flag forces the delta to zero
    always_comb begin
        w_dx = 18'sd0;
        w_dy = 18'sd0;
        if (!r_b0[X_OVF_BIT])
            w_dx = $signed({{9{r_b0[X_SIGN_BIT]}}, r_b0[X_SIGN_BIT], r_b1});
        if (!r_b0[Y_OVF_BIT])
            w_dy = $signed({{9{r_b0[Y_SIGN_BIT]}}, r_b0[Y_SIGN_BIT], w_byte_data});
        // PS/2 Y is up-positive; screen Y is down-positive
        w_sum_x = $signed({2'b00, mouse_x}) + w_dx;
        w_sum_y = $signed({2'b00, mouse_y}) - w_dy;
    end

    // Packet assembler: resync on byte 0, restart on any frame error, apply on byte 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= 2'd0;
            r_b0        <= '0;
            r_b1        <= '0;
            mouse_x     <= 16'(X_MAX / 2);
            mouse_y     <= 16'(Y_MAX / 2);
            mouse_click <= '0;
            pkt_valid   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= w_byte_err;
            if (w_byte_err) begin
                r_idx <= 2'd0;
            end else if (w_byte_valid) begin
                case (r_idx)
                    2'd0: begin
                        if (w_byte_data[SYNC_BIT]) begin
                            r_b0  <= w_byte_data;
                            r_idx <= 2'd1;
                        end
                    end
                    2'd1: begin
                        r_b1  <= w_byte_data;
                        r_idx <= 2'd2;
                    end
                    default: begin
                        r_idx       <= 2'd0;
                        mouse_x     <= clamp_pos(w_sum_x, X_MAX_W);
                        mouse_y     <= clamp_pos(w_sum_y, Y_MAX_W);
                        mouse_click <= {5'b0, r_b0[BTN_MIDDLE_BIT], r_b0[BTN_RIGHT_BIT],
                                        r_b0[BTN_LEFT_BIT]};
                        pkt_valid   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Directed bench for ps2_mouse_decoder: bit-banged PS/2 frames, hand-computed cursor expectations.
// Timeout shortened to 1000 clocks so the abort case stays well inside the cycle budget.
// Parity expectations follow PS2_PARITY_CHECK_EN when defined.
module tb_ps2_mouse_decoder;

    localparam int H = 20;  // PS/2 half bit period in system clocks

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk_i = 1'b1;
    logic        ps2_data_i = 1'b1;
    logic [15:0] mouse_x;
    logic [15:0] mouse_y;
    logic [7:0]  mouse_click;
    logic        pkt_valid;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int pv_cnt = 0;
    int fe_cnt = 0;
    int exp_pv = 0;
    int exp_fe = 0;

    ps2_mouse_decoder #(
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .mouse_click (mouse_click),
        .pkt_valid   (pkt_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // count high cycles of each pulse output; one-clock pulses give one count per event
    always @(posedge clk) begin
        if (pkt_valid) pv_cnt++;
        if (frame_err) fe_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_xyc(input string tag, input int x, input int y, input int c);
        check({tag, ".x"}, 32'(mouse_x), 32'(x));
        check({tag, ".y"}, 32'(mouse_y), 32'(y));
        check({tag, ".click"}, 32'(mouse_click), 32'(c));
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".pkts"}, 32'(pv_cnt), 32'(exp_pv));
        check({tag, ".errs"}, 32'(fe_cnt), 32'(exp_fe));
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data_i = b;
        clks(H);
        ps2_clk_i = 1'b0;
        clks(H);
        ps2_clk_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_bit);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(stop_bit);
        ps2_data_i = 1'b1;
        clks(3 * H);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clks(5);
        rst_n = 1'b1;
        clks(5);
    endtask

    initial begin
        int ex, ey;

        // reset state
        clks(5);
        check_xyc("reset", 319, 239, 0);
        check("reset.pkt_valid", 32'(pkt_valid), 32'd0);
        check("reset.frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        clks(5);

        // basic packet: dx=+10, dy=+5 (screen up), left button
        send_pkt(8'h09, 8'h0A, 8'h05);
        exp_pv++;
        check_xyc("basic", 329, 234, 1);
        check_counts("basic");

        // left clamp: -256 then four -128 steps, must saturate at 0
        do_reset();
        send_pkt(8'h18, 8'h00, 8'h00);
        exp_pv++;
        check_xyc("xneg256", 63, 239, 0);
        send_pkt(8'h18, 8'h80, 8'h00);
        exp_pv++;
        check("xclamp1.x", 32'(mouse_x), 32'd0);
        for (int i = 0; i < 3; i++) send_pkt(8'h18, 8'h80, 8'h00);
        exp_pv += 3;
        check_xyc("xclamp4", 0, 239, 0);
        check_counts("xclamp4");

        // a start bit sampled high is ignored, then byte 0 without sync bit is dropped
        do_reset();
        ps2_bit(1'b1);
        ps2_data_i = 1'b1;
        clks(3 * H);
        send_byte(8'h00);
        check_counts("resync.drop");
        send_pkt(8'h08, 8'h01, 8'h01);
        exp_pv++;
        check_xyc("resync", 320, 238, 0);
        check_counts("resync");

        // wrong parity on byte 0
        send_frame(8'h08, 1'b1, 1'b1);
        send_byte(8'h01);
        send_byte(8'h01);
`ifdef PS2_PARITY_CHECK_EN
        exp_fe++;
        ex = 320; ey = 238;
`else
        exp_pv++;
        ex = 321; ey = 237;
`endif
        check_xyc("parity", ex, ey, 0);
        check_counts("parity");

        // timeout after 4 data bits, then a full packet must decode
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data_i = 1'b1;
        clks(1500);
        exp_fe++;
        check_counts("timeout");
        check_xyc("timeout", ex, ey, 0);
        send_pkt(8'h08, 8'h02, 8'h03);
        exp_pv++;
        ex += 2; ey -= 3;
        check_xyc("post_timeout", ex, ey, 0);

        // upper clamps: +127 x three times, y moves by +256 downward
        for (int i = 0; i < 3; i++) send_pkt(8'h28, 8'h7F, 8'h00);
        exp_pv += 3;
        check_xyc("hiclamp", 639, 479, 0);

        // X overflow: delta ignored, buttons still update
        send_pkt(8'h4A, 8'h05, 8'h00);
        exp_pv++;
        check_xyc("xovf", 639, 479, 2);

        // bad stop bit mid-packet restarts the packet at byte 0
        send_byte(8'h08);
        send_frame(8'h55, 1'b0, 1'b0);
        exp_fe++;
        check_counts("badstop");
        check_xyc("badstop", 639, 479, 2);
        send_pkt(8'h09, 8'h00, 8'h01);
        exp_pv++;
        check_xyc("after_badstop", 639, 478, 1);
        check_counts("after_badstop");

        // reset in the middle of byte 1
        send_byte(8'h0C);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_n = 1'b0;
        #2;
        check_xyc("midreset", 319, 239, 0);
        ps2_data_i = 1'b1;
        clks(5);
        rst_n = 1'b1;
        clks(5);
        send_pkt(8'h0C, 8'h00, 8'h00);
        exp_pv++;
        check_xyc("after_reset", 319, 239, 4);
        check_counts("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
